// File: rtl/tpu_mmio_seq_if.sv
// Host access bus for the systolic matrix engine front end.
// Bus protocol: req is a one-cycle request that the slave always accepts,
// so there is no ready signal. r_w selects write (1) or read (0). Every
// accepted read is answered by rd_valid high for exactly one cycle, one
// cycle after the req, with data_out holding the read data.
interface tpu_mmio_seq_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
) ();
  logic             req;
  logic             r_w;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] data_in;
  logic [DATAW-1:0] data_out;
  logic             rd_valid;

  modport master (
    output req, r_w, addr, data_in,
    input  data_out, rd_valid
  );

  modport slave (
    input  req, r_w, addr, data_in,
    output data_out, rd_valid
  );
endinterface

// File: rtl/tpu_mmio_seq.sv
// Memory-mapped front end and compute sequencer for a DIM x DIM systolic
// matrix engine. Decodes host accesses into A/B memory and array strobes,
// sequences an optional C-clear followed by the matmul run, and keeps
// sticky done/err status with a one-cycle completion pulse.
module tpu_mmio_seq #(
  parameter int               BITS_AB   = 8,
  parameter int               BITS_C    = 16,
  parameter int               DIM       = 8,
  parameter int               ADDRW     = 16,
  parameter int               DATAW     = 64,
  parameter logic [ADDRW-1:0] A_BASE    = 16'h0100,
  parameter logic [ADDRW-1:0] B_BASE    = 16'h0200,
  parameter logic [ADDRW-1:0] C_BASE    = 16'h0300,
  parameter logic [ADDRW-1:0] CTRL_ADDR = 16'h0400,
  parameter logic [ADDRW-1:0] STAT_ADDR = 16'h0408,
  localparam int              RW        = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int              CD        = DIM * BITS_C
) (
  input  logic           clk,
  input  logic           rst,
  tpu_mmio_seq_if.slave  host,
  output logic           busy,
  output logic           done_irq,
  output logic           a_wr_en,
  output logic           a_en,
  output logic [RW-1:0]  a_row,
  output logic           b_wr_en,
  output logic           b_en,
  output logic           sa_en,
  output logic           sa_wr_en,
  output logic [RW-1:0]  c_row,
  output logic [CD-1:0]  c_wdata,
  input  logic [CD-1:0]  c_rdata,
  output logic [1:0]     dbg_state
);

  // Geometry: SB bytes per beat, CW beats per C row.
  localparam int SB   = DATAW / 8;
  localparam int SBL  = $clog2(SB);
  localparam int CW   = CD / DATAW;
  localparam int BW   = (CW > 1) ? $clog2(CW) : 1;
  localparam int CNTW = $clog2(3 * DIM);

  localparam logic [ADDRW-1:0] AB_SPAN    = ADDRW'(DIM * SB);
  localparam logic [ADDRW-1:0] C_SPAN     = ADDRW'(DIM * CW * SB);
  localparam logic [ADDRW-1:0] ALIGN_MASK = ~ADDRW'(SB - 1);
  localparam logic [ADDRW-1:0] CW_A       = ADDRW'(CW);
  localparam logic [CNTW-1:0]  CLR_LAST   = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0]  RUN_LAST   = CNTW'(3 * DIM - 3);

  // A/B rows must be exactly one beat wide and C rows a whole number of beats.
  if ((DIM * BITS_AB != DATAW) || (CW < 1) || (CW * DATAW != CD)) begin : g_bad_geometry
    $error("tpu_mmio_seq: unsupported DIM/BITS_AB/BITS_C/DATAW combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [DATAW-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;

  // Decode results.
  logic [ADDRW-1:0] addr_al;
  logic [ADDRW-1:0] a_off, b_off, c_off, c_idx;
  logic             a_hit, b_hit, c_hit, ctrl_hit, stat_hit;
  logic [RW-1:0]    a_idx, c_ridx;
  logic [BW-1:0]    c_beat;
  logic             wr, rd;
  logic             ctrl_start;
  logic             err_set;
  logic [DATAW-1:0] rdata;

  // Host request qualifiers; nothing is accepted while reset is held.
  assign wr = host.req &  host.r_w & ~rst;
  assign rd = host.req & ~host.r_w & ~rst;

  // Address decode: sub-beat address bits are ignored everywhere.
  always_comb begin
    addr_al  = host.addr & ALIGN_MASK;
    a_off    = addr_al - A_BASE;
    b_off    = addr_al - B_BASE;
    c_off    = addr_al - C_BASE;
    c_idx    = c_off >> SBL;
    a_hit    = (addr_al >= A_BASE) && (a_off < AB_SPAN);
    b_hit    = (addr_al >= B_BASE) && (b_off < AB_SPAN);
    c_hit    = (addr_al >= C_BASE) && (c_off < C_SPAN);
    ctrl_hit = (addr_al == CTRL_ADDR);
    stat_hit = (addr_al == STAT_ADDR);
    a_idx    = RW'(a_off >> SBL);
    c_ridx   = RW'(c_idx / CW_A);
    c_beat   = BW'(c_idx % CW_A);
  end

  assign ctrl_start = wr & ctrl_hit & host.data_in[0];

  // A write that would disturb a running computation is dropped and flagged.
  assign err_set = busy & wr & (a_hit | b_hit | c_hit | ctrl_start);

  // FSM state and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state plus all memory/array strobes; host strobes only act in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done_irq = 1'b0;
    a_wr_en  = 1'b0;
    a_en     = 1'b0;
    a_row    = '0;
    b_wr_en  = 1'b0;
    b_en     = 1'b0;
    sa_en    = 1'b0;
    sa_wr_en = 1'b0;
    c_row    = '0;
    c_wdata  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (wr && a_hit) begin
          a_wr_en = 1'b1;
          a_row   = a_idx;
        end
        if (wr && b_hit) begin
          b_wr_en = 1'b1;
          b_en    = 1'b1;
        end
        if (wr && c_hit) begin
          // Read-modify-write: only the addressed beat of the row changes.
          sa_wr_en = 1'b1;
          c_row    = c_ridx;
          c_wdata  = c_rdata;
          c_wdata[int'(c_beat)*DATAW +: DATAW] = host.data_in;
        end
        if (rd && c_hit) begin
          c_row = c_ridx;
        end
        if (ctrl_start) begin
          cnt_d   = '0;
          state_d = host.data_in[1] ? S_RUN : S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy     = 1'b1;
        sa_wr_en = 1'b1;
        c_row    = RW'(cnt_q);
        if (cnt_q == CLR_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        a_en  = 1'b1;
        b_en  = 1'b1;
        sa_en = 1'b1;
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_DONE: begin
        done_irq = 1'b1;
        if (rd && c_hit) begin
          c_row = c_ridx;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read data selection; C contents are hidden while the array is in use.
  always_comb begin
    rdata = '0;
    if (c_hit && (state_q == S_IDLE || state_q == S_DONE)) begin
      rdata = c_rdata[int'(c_beat)*DATAW +: DATAW];
    end else if (stat_hit) begin
      rdata = {{(DATAW-3){1'b0}}, err_q, done_q, busy};
    end
  end

  // Sticky status and readback next values; a done set beats a same-cycle clear.
  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    if (wr && stat_hit) begin
      if (host.data_in[1]) done_d = 1'b0;
      if (host.data_in[2]) err_d  = 1'b0;
    end
    if (state_q == S_DONE) done_d = 1'b1;
    if (err_set)           err_d  = 1'b1;
    data_out_d = rd ? rdata : data_out_q;
    rd_valid_d = rd;
  end

  // Status and readback registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign host.data_out = data_out_q;
  assign host.rd_valid = rd_valid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_tpu_mmio_seq.sv
// Directed bench for tpu_mmio_seq at DIM=8, DATAW=64, BITS_C=16.
module tb_tpu_mmio_seq;
  logic         clk;
  logic         rst;
  logic         busy, done_irq, a_wr_en, a_en, b_wr_en, b_en, sa_en, sa_wr_en;
  logic [2:0]   a_row, c_row;
  logic [127:0] c_wdata, c_rdata;
  logic [1:0]   dbg_state;
  int           n_checks;
  int           n_fail;

  tpu_mmio_seq_if #(.ADDRW(16), .DATAW(64)) bus ();

  tpu_mmio_seq dut (
    .clk      (clk),
    .rst      (rst),
    .host     (bus),
    .busy     (busy),
    .done_irq (done_irq),
    .a_wr_en  (a_wr_en),
    .a_en     (a_en),
    .a_row    (a_row),
    .b_wr_en  (b_wr_en),
    .b_en     (b_en),
    .sa_en    (sa_en),
    .sa_wr_en (sa_wr_en),
    .c_row    (c_row),
    .c_wdata  (c_wdata),
    .c_rdata  (c_rdata),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic rw, input logic [15:0] a, input logic [63:0] d);
    bus.req = 1'b1; bus.r_w = rw; bus.addr = a; bus.data_in = d;
  endtask

  task automatic idle();
    bus.req = 1'b0; bus.r_w = 1'b0; bus.addr = '0; bus.data_in = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Expected {busy, sa_wr_en, a_en, b_en, sa_en, done_irq} in cycle k after the start write.
  function automatic logic [5:0] phase_exp(input int k, input bit with_clear);
    int run0;
    run0 = with_clear ? 9 : 1;
    if (with_clear && k >= 1 && k <= 8) return 6'b110000;
    if (k >= run0 && k < run0 + 22)     return 6'b101110;
    if (k == run0 + 22)                 return 6'b000001;
    return 6'b000000;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'h0100, 64'h1);
    #2;
    n_checks++;
    if ({busy, done_irq, a_wr_en, a_en, b_wr_en, b_en, sa_en, sa_wr_en, bus.rd_valid} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0",
               {busy, done_irq, a_wr_en, a_en, b_wr_en, b_en, sa_en, sa_wr_en, bus.rd_valid});
    end
    n_checks++;
    if ({bus.data_out, a_row, c_row, c_wdata, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: data_out %h a_row %0d c_row %0d c_wdata %h state %0d expected all 0",
               bus.data_out, a_row, c_row, c_wdata, dbg_state);
    end
    idle();
    step();
    rst = 1'b0;
    step();
    drive(1'b0, 16'h0408, 64'h0);
    step(); idle();
    n_checks++;
    if ({bus.rd_valid, bus.data_out} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL reset_stat: rd_valid %b data %h expected 1 / 0", bus.rd_valid, bus.data_out);
    end
  endtask

  task automatic test_a_writes();
    for (int r = 0; r < 8; r++) begin
      drive(1'b1, 16'h0100 + 16'(r * 8), 64'h0);
      #1;
      n_checks++;
      if ({a_wr_en, a_row, b_wr_en, sa_wr_en} !== {1'b1, 3'(r), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL a_write row %0d: a_wr_en %b a_row %0d b_wr_en %b sa_wr_en %b", r, a_wr_en, a_row, b_wr_en, sa_wr_en);
      end
      step();
    end
    drive(1'b1, 16'h010B, 64'h0);
    #1;
    n_checks++;
    if ({a_wr_en, a_row} !== {1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL a_unaligned: a_wr_en %b a_row %0d expected 1 / 1", a_wr_en, a_row);
    end
    step();
    drive(1'b1, 16'h0140, 64'h0);
    #1;
    n_checks++;
    if ({a_wr_en, b_wr_en, sa_wr_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL a_out_of_range: strobes %b expected 000", {a_wr_en, b_wr_en, sa_wr_en});
    end
    step();
    drive(1'b0, 16'h0100, 64'h0);
    #1;
    n_checks++;
    if (a_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL a_read_no_write: a_wr_en %b expected 0", a_wr_en);
    end
    step(); idle();
  endtask

  task automatic test_b_writes();
    int pulses;
    pulses = 0;
    for (int r = 0; r < 8; r++) begin
      drive(1'b1, 16'h0200 + 16'(r * 8), 64'h0);
      #1;
      if (b_wr_en && b_en) pulses++;
      n_checks++;
      if ({b_wr_en, b_en, a_wr_en} !== 3'b110) begin
        n_fail++;
        $display("FAIL b_write %0d: b_wr_en %b b_en %b a_wr_en %b", r, b_wr_en, b_en, a_wr_en);
      end
      step();
    end
    drive(1'b1, 16'h0240, 64'h0);
    #1;
    if (b_wr_en) pulses++;
    step(); idle();
    n_checks++;
    if (pulses !== 8) begin
      n_fail++;
      $display("FAIL b_pulse_count: got %0d expected 8", pulses);
    end
  endtask

  task automatic test_c_access();
    c_rdata = {64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111};
    drive(1'b1, 16'h0318, 64'hAAAA_AAAA_AAAA_AAAA);
    #1;
    n_checks++;
    if ({sa_wr_en, c_row, c_wdata} !== {1'b1, 3'd1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h1111_1111_1111_1111}) begin
      n_fail++;
      $display("FAIL c_rmw_upper: sa_wr_en %b c_row %0d c_wdata %h", sa_wr_en, c_row, c_wdata);
    end
    step();
    drive(1'b1, 16'h0330, 64'h5555_5555_5555_5555);
    #1;
    n_checks++;
    if ({sa_wr_en, c_row, c_wdata} !== {1'b1, 3'd3, 64'h1111_1111_1111_1111, 64'h5555_5555_5555_5555}) begin
      n_fail++;
      $display("FAIL c_rmw_lower: sa_wr_en %b c_row %0d c_wdata %h", sa_wr_en, c_row, c_wdata);
    end
    step();
    drive(1'b1, 16'h0380, 64'h5555_5555_5555_5555);
    #1;
    n_checks++;
    if (sa_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL c_out_of_range: sa_wr_en %b expected 0", sa_wr_en);
    end
    step();
    c_rdata = {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_0011_2233};
    drive(1'b0, 16'h0318, 64'h0);
    #1;
    n_checks++;
    if ({c_row, sa_wr_en} !== {3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL c_read_row: c_row %0d sa_wr_en %b expected 1 / 0", c_row, sa_wr_en);
    end
    step();
    n_checks++;
    if ({bus.rd_valid, bus.data_out} !== {1'b1, 64'hDEAD_BEEF_0123_4567}) begin
      n_fail++;
      $display("FAIL c_read_upper: rd_valid %b data %h", bus.rd_valid, bus.data_out);
    end
    drive(1'b0, 16'h0310, 64'h0);
    step();
    n_checks++;
    if ({bus.rd_valid, bus.data_out} !== {1'b1, 64'h89AB_CDEF_0011_2233}) begin
      n_fail++;
      $display("FAIL c_read_lower: rd_valid %b data %h", bus.rd_valid, bus.data_out);
    end
    drive(1'b0, 16'h037F, 64'h0);
    #1;
    n_checks++;
    if (c_row !== 3'd7) begin
      n_fail++;
      $display("FAIL c_read_last_row: c_row %0d expected 7", c_row);
    end
    step();
    n_checks++;
    if (bus.data_out !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++;
      $display("FAIL c_read_last_beat: data %h", bus.data_out);
    end
    drive(1'b0, 16'h0500, 64'h0);
    step(); idle();
    n_checks++;
    if ({bus.rd_valid, bus.data_out} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL unmapped_read: rd_valid %b data %h expected 1 / 0", bus.rd_valid, bus.data_out);
    end
    step();
    n_checks++;
    if ({bus.rd_valid, bus.data_out} !== {1'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL rd_valid_pulse: rd_valid %b data %h expected 0 / 0", bus.rd_valid, bus.data_out);
    end
  endtask

  task automatic test_clear_run();
    logic [5:0] exp_v;
    c_rdata = '1;
    drive(1'b1, 16'h0400, 64'h1);
    step(); idle();
    for (int k = 1; k <= 32; k++) begin
      #1;
      exp_v = phase_exp(k, 1'b1);
      n_checks++;
      if ({busy, sa_wr_en, a_en, b_en, sa_en, done_irq} !== exp_v) begin
        n_fail++;
        $display("FAIL clear_run cycle %0d: got %b expected %b", k, {busy, sa_wr_en, a_en, b_en, sa_en, done_irq}, exp_v);
      end
      if (k <= 8) begin
        n_checks++;
        if ({c_row, c_wdata} !== {3'(k - 1), 128'h0}) begin
          n_fail++;
          $display("FAIL clear_row cycle %0d: c_row %0d c_wdata %h", k, c_row, c_wdata);
        end
      end
      step();
    end
    drive(1'b0, 16'h0408, 64'h0);
    step(); idle();
    n_checks++;
    if ({bus.rd_valid, bus.data_out} !== {1'b1, 64'h2}) begin
      n_fail++;
      $display("FAIL clear_run_stat: rd_valid %b data %h expected 1 / 2", bus.rd_valid, bus.data_out);
    end
  endtask

  task automatic test_accumulate();
    logic [5:0] exp_v;
    drive(1'b1, 16'h0408, 64'h2);
    step();
    drive(1'b0, 16'h0408, 64'h0);
    step();
    n_checks++;
    if (bus.data_out !== 64'h0) begin
      n_fail++;
      $display("FAIL w1c_done: data %h expected 0", bus.data_out);
    end
    drive(1'b1, 16'h0400, 64'h3);
    step(); idle();
    for (int k = 1; k <= 24; k++) begin
      #1;
      exp_v = phase_exp(k, 1'b0);
      n_checks++;
      if ({busy, sa_wr_en, a_en, b_en, sa_en, done_irq} !== exp_v) begin
        n_fail++;
        $display("FAIL accum_run cycle %0d: got %b expected %b", k, {busy, sa_wr_en, a_en, b_en, sa_en, done_irq}, exp_v);
      end
      step();
    end
    drive(1'b0, 16'h0408, 64'h0);
    step(); idle();
    n_checks++;
    if (bus.data_out !== 64'h2) begin
      n_fail++;
      $display("FAIL accum_stat: data %h expected 2", bus.data_out);
    end
  endtask

  task automatic test_busy_err();
    logic [5:0] exp_v;
    drive(1'b1, 16'h0400, 64'h3);
    step(); idle();
    for (int k = 1; k <= 24; k++) begin
      idle();
      if (k == 1)  drive(1'b1, 16'h0408, 64'h2);
      if (k == 3)  drive(1'b1, 16'h0100, 64'hFF);
      if (k == 5)  drive(1'b1, 16'h0400, 64'h1);
      if (k == 7)  drive(1'b1, 16'h0318, 64'h1234);
      if (k == 10) drive(1'b0, 16'h0408, 64'h0);
      if (k == 23) drive(1'b1, 16'h0408, 64'h2);
      #1;
      exp_v = phase_exp(k, 1'b0);
      n_checks++;
      if ({busy, sa_wr_en, a_en, b_en, sa_en, done_irq} !== exp_v) begin
        n_fail++;
        $display("FAIL busy_run cycle %0d: got %b expected %b", k, {busy, sa_wr_en, a_en, b_en, sa_en, done_irq}, exp_v);
      end
      if (k == 3) begin
        n_checks++;
        if ({a_wr_en, a_en} !== 2'b01) begin
          n_fail++;
          $display("FAIL busy_a_write: a_wr_en %b a_en %b expected 0 / 1", a_wr_en, a_en);
        end
      end
      if (k == 11) begin
        n_checks++;
        if (bus.data_out !== 64'h5) begin
          n_fail++;
          $display("FAIL busy_stat: data %h expected 5", bus.data_out);
        end
      end
      step();
    end
    idle();
    drive(1'b0, 16'h0408, 64'h0);
    step();
    n_checks++;
    if (bus.data_out !== 64'h6) begin
      n_fail++;
      $display("FAIL err_done_sticky: data %h expected 6", bus.data_out);
    end
    drive(1'b1, 16'h0408, 64'h6);
    step();
    drive(1'b0, 16'h0408, 64'h0);
    step(); idle();
    n_checks++;
    if (bus.data_out !== 64'h0) begin
      n_fail++;
      $display("FAIL w1c_both: data %h expected 0", bus.data_out);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [5:0] exp_v;
    drive(1'b1, 16'h0400, 64'h3);
    step(); idle();
    for (int k = 1; k < 10; k++) begin
      idle();
      if (k == 2) drive(1'b1, 16'h0200, 64'h0);
      step();
    end
    idle();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, a_en, b_en, sa_en, sa_wr_en, a_wr_en, b_wr_en, done_irq, dbg_state} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %b expected 0",
               {busy, a_en, b_en, sa_en, sa_wr_en, a_wr_en, b_wr_en, done_irq, dbg_state});
    end
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0408, 64'h0);
    step(); idle();
    n_checks++;
    if (bus.data_out !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_clears_status: data %h expected 0", bus.data_out);
    end
    drive(1'b1, 16'h0400, 64'h3);
    step(); idle();
    for (int k = 1; k <= 24; k++) begin
      #1;
      exp_v = phase_exp(k, 1'b0);
      n_checks++;
      if ({busy, sa_wr_en, a_en, b_en, sa_en, done_irq} !== exp_v) begin
        n_fail++;
        $display("FAIL rerun cycle %0d: got %b expected %b", k, {busy, sa_wr_en, a_en, b_en, sa_en, done_irq}, exp_v);
      end
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    c_rdata  = '0;
    idle();
    test_reset();
    test_a_writes();
    test_b_writes();
    test_c_access();
    test_clear_run();
    test_accumulate();
    test_busy_err();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tpu_mmio_seq.md
Name: tpu_mmio_seq

Overview:
- Parametrised memory-mapped front end and compute sequencer for a DIM x DIM systolic matrix engine.
- Decodes host read/write accesses into strobes for the A memory, B memory and systolic array.
- Runs the matmul through an explicit FSM with optional C-clear, sticky status and a completion pulse.
- Replaces hardwired DIM=8/DATAW=64 decode with generalised row/beat arithmetic, a request strobe and registered readback.

Parameters:
BITS_AB, 8, A/B element width
BITS_C, 16, C accumulator element width
DIM, 8, array dimension; DIM*BITS_AB must equal DATAW
ADDRW, 16, host address width
DATAW, 64, host data width; CW = DIM*BITS_C/DATAW beats per C row (integer, >=1)
A_BASE, 16'h0100, A region base
B_BASE, 16'h0200, B region base
C_BASE, 16'h0300, C region base
CTRL_ADDR, 16'h0400, control register
STAT_ADDR, 16'h0408, status register

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  1  host access strobe, one access per cycle when high
r_w  in  1  1=write, 0=read
addr  in  ADDRW  byte address; beat stride SB=DATAW/8
data_in  in  DATAW  host write data
data_out  out  DATAW  registered read data
rd_valid  out  1  data_out valid, one cycle after read req
busy  out  1  FSM not IDLE
done_irq  out  1  one-cycle pulse on compute completion
a_wr_en  out  1  write data_in as A row a_row
a_en  out  1  A memory shift enable
a_row  out  $clog2(DIM)  A row index
b_wr_en  out  1  push data_in into B memory
b_en  out  1  B memory shift enable
sa_en  out  1  systolic array compute enable
sa_wr_en  out  1  write c_wdata into array row c_row
c_row  out  $clog2(DIM)  C row index
c_wdata  out  DIM*BITS_C  C row write data
c_rdata  in  DIM*BITS_C  array output for row c_row (combinational)

Behaviour:
- Decode (req=1): A hit if A_BASE <= addr < A_BASE+DIM*SB, row=(addr-A_BASE)/SB. B the same with B_BASE. C hit if C_BASE <= addr < C_BASE+DIM*CW*SB, row=(addr-C_BASE)/(CW*SB), beat=((addr-C_BASE)/SB)%CW. Unaligned low bits are ignored. Other addresses are ignored, with no error.
- IDLE writes:
  - A hit: a_wr_en=1, a_row=row.
  - B hit: b_wr_en=1 and b_en=1.
  - C hit: sa_wr_en=1, c_row=row, c_wdata=c_rdata with bits [beat*DATAW +: DATAW] replaced by data_in (read-modify-write).
  - All decode strobes are combinational, same cycle as req.
- Reads (any state):
  - C hit in IDLE/DONE: c_row=row; data_out <= c_rdata[beat*DATAW +: DATAW] next cycle.
  - STAT_ADDR: data_out <= {0..., err, done, busy} in bits [2:0].
  - C hit while RUN/CLEAR, or unmapped address: returns 0.
  - rd_valid pulses exactly one cycle after every read req.
- CTRL write: data_in[0]=start, data_in[1]=accumulate.
  - start=1 in IDLE: go to CLEAR if accumulate=0, else RUN.
  - start=0: no effect.
- STAT write: W1C; data_in[1] clears done, data_in[2] clears err.
- FSM states IDLE, CLEAR, RUN, DONE; counter cnt, width $clog2(3*DIM).
  - CLEAR: DIM cycles, cnt 0..DIM-1. sa_wr_en=1, c_row=cnt, c_wdata=0. Then RUN with cnt=0.
  - RUN: exactly 3*DIM-2 cycles with a_en=b_en=sa_en=1. Then DONE.
  - DONE: one cycle; done_irq=1, set sticky done. Then IDLE.
  - busy=1 in CLEAR and RUN only.
- Errors: A/B/C/CTRL-start write while busy is dropped and sets sticky err; the FSM is unaffected. A STAT write while busy is allowed. If a W1C clear and a done set land in the same cycle, set wins.
- In CLEAR/RUN/DONE, host-driven a_wr_en, b_wr_en and sa_wr_en are suppressed; only FSM-driven strobes drive the outputs.
- Reset: state=IDLE, cnt=0, done=err=0. data_out=0, rd_valid=0, done_irq=0. All strobes 0, a_row=c_row=0, c_wdata=0. Reset mid-RUN aborts immediately; array and memories are left untouched.

Test Plan:
- DIM=8: write A rows 0..7 at 0x100..0x138 -> a_wr_en with a_row 0..7; b writes at 0x200..0x238 -> 8 b_wr_en pulses.
- C write 0x318 data 0xAAAA..., c_rdata=0x1111... -> c_row=1, c_wdata upper 64b=0xAAAA..., lower 64b=0x1111...; read 0x318 -> data_out upper beat next cycle, rd_valid=1.
- CTRL write 0x1 -> 8 CLEAR cycles zeroing rows 0..7, then 22 RUN cycles with sa_en=1, done_irq pulse at cycle 31; STAT read = 3'b010.
- CTRL write 0x3 -> no CLEAR, RUN starts next cycle, done_irq after 22 RUN cycles.
- Write 0x100 during RUN -> a_wr_en stays 0, STAT err=1; STAT write 0x6 -> reads 0.
- Assert rst at RUN cycle 10 -> busy=0, all strobes 0 same edge; new start runs a full 22 RUN cycles.
